// File: rtl/adc_lane_aligner.sv
// ADC lane aligner: bitslip-trains deserializer word alignment against a
// known frame-lane pattern, monitors lock, and outputs the bit-interleaved
// sample with valid/lock/error status.
module adc_lane_aligner #(
  parameter int         LANES         = 2,
  parameter int         BITS          = 8,
  parameter logic [7:0] FRAME_PATTERN = 8'hF0,
  parameter int         SETTLE_CYCLES = 4,
  parameter int         MAX_SLIPS     = 7,
  parameter int         LOCK_COUNT    = 16,
  parameter int         ERR_LIMIT     = 4
) (
  input  logic                              CLK,
  input  logic                              RST_N,
  input  logic                              start,
  input  logic [LANES*BITS-1:0]             lanes_in,
  input  logic [BITS-1:0]                   frame_in,
  output logic                              bitslip,
  output logic [LANES*BITS-1:0]             d_out,
  output logic                              d_valid,
  output logic                              locked,
  output logic                              align_err,
  output logic [$clog2(MAX_SLIPS+1)-1:0]    slip_count
);

  localparam int SCW = $clog2(MAX_SLIPS + 1);
  localparam int STW = $clog2(SETTLE_CYCLES + 1);
  localparam int MCW = $clog2(LOCK_COUNT + 1);
  localparam int ECW = $clog2(ERR_LIMIT + 1);

  localparam logic [BITS-1:0] FRAME     = FRAME_PATTERN[BITS-1:0];
  localparam logic [SCW-1:0]  SLIP_MAX  = SCW'(MAX_SLIPS);
  localparam logic [STW-1:0]  SETTLE_LD = STW'(SETTLE_CYCLES);
  localparam logic [MCW-1:0]  LOCK_W    = MCW'(LOCK_COUNT);
  localparam logic [ECW-1:0]  ERR_W     = ECW'(ERR_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_SLIP,
    S_VERIFY,
    S_LOCKED,
    S_FAIL
  } state_t;

  state_t                  state_q;
  logic [STW-1:0]          settle_cnt_q;
  logic [SCW-1:0]          slip_cnt_q;
  logic [MCW-1:0]          match_cnt_q;
  logic [ECW-1:0]          err_cnt_q;
  logic                    bitslip_q;
  logic                    locked_q;
  logic                    align_err_q;
  logic                    d_valid_q;
  logic [LANES*BITS-1:0]   d_out_q;
  logic [LANES*BITS-1:0]   d_out_d;
  logic                    frame_match;
  logic [SCW-1:0]          slip_inc;

  // Frame compare, saturating slip increment and bit interleave
  always_comb begin
    frame_match = (frame_in == FRAME);
    slip_inc    = (slip_cnt_q == SLIP_MAX) ? slip_cnt_q : slip_cnt_q + 1'b1;
    d_out_d     = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      for (int unsigned j = 0; j < BITS; j++) begin
        d_out_d[(BITS-1-j)*LANES + l] = lanes_in[l*BITS + j];
      end
    end
  end

  // Sample register: one cycle of latency from lanes_in
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      d_out_q <= '0;
    end else begin
      d_out_q <= d_out_d;
    end
  end

  // Training / lock-monitor FSM with registered status outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= S_IDLE;
      settle_cnt_q <= '0;
      slip_cnt_q   <= '0;
      match_cnt_q  <= '0;
      err_cnt_q    <= '0;
      bitslip_q    <= 1'b0;
      locked_q     <= 1'b0;
      align_err_q  <= 1'b0;
      d_valid_q    <= 1'b0;
    end else begin
      bitslip_q <= 1'b0;
      d_valid_q <= (state_q == S_LOCKED) && frame_match && !start;
      if (start) begin
        // start overrides every other transition, including lock loss and FAIL
        state_q      <= S_SETTLE;
        settle_cnt_q <= SETTLE_LD;
        slip_cnt_q   <= '0;
        match_cnt_q  <= '0;
        err_cnt_q    <= '0;
        locked_q     <= 1'b0;
        align_err_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            state_q <= S_IDLE;
          end
          S_SETTLE: begin
            if (settle_cnt_q <= STW'(1)) begin
              state_q <= S_CHECK;
            end else begin
              settle_cnt_q <= settle_cnt_q - 1'b1;
            end
          end
          S_CHECK: begin
            if (frame_match) begin
              if (LOCK_COUNT == 1) begin
                state_q   <= S_LOCKED;
                locked_q  <= 1'b1;
                err_cnt_q <= '0;
              end else begin
                state_q     <= S_VERIFY;
                match_cnt_q <= MCW'(1);
              end
            end else if (slip_cnt_q == SLIP_MAX) begin
              state_q     <= S_FAIL;
              align_err_q <= 1'b1;
            end else begin
              // bitslip and slip_count move together on entry to SLIP
              state_q    <= S_SLIP;
              bitslip_q  <= 1'b1;
              slip_cnt_q <= slip_inc;
            end
          end
          S_SLIP: begin
            state_q      <= S_SETTLE;
            settle_cnt_q <= SETTLE_LD;
          end
          S_VERIFY: begin
            if (frame_match) begin
              if (match_cnt_q + 1'b1 == LOCK_W) begin
                state_q     <= S_LOCKED;
                locked_q    <= 1'b1;
                err_cnt_q   <= '0;
                match_cnt_q <= '0;
              end else begin
                match_cnt_q <= match_cnt_q + 1'b1;
              end
            end else begin
              match_cnt_q <= '0;
              if (slip_cnt_q == SLIP_MAX) begin
                state_q     <= S_FAIL;
                align_err_q <= 1'b1;
              end else begin
                state_q    <= S_SLIP;
                bitslip_q  <= 1'b1;
                slip_cnt_q <= slip_inc;
              end
            end
          end
          S_LOCKED: begin
            if (frame_match) begin
              err_cnt_q <= '0;
            end else if (err_cnt_q + 1'b1 == ERR_W) begin
              state_q      <= S_SETTLE;
              settle_cnt_q <= SETTLE_LD;
              locked_q     <= 1'b0;
              slip_cnt_q   <= '0;
              err_cnt_q    <= '0;
            end else begin
              err_cnt_q <= err_cnt_q + 1'b1;
            end
          end
          S_FAIL: begin
            state_q <= S_FAIL;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bitslip    = bitslip_q;
  assign d_out      = d_out_q;
  assign d_valid    = d_valid_q;
  assign locked     = locked_q;
  assign align_err  = align_err_q;
  assign slip_count = slip_cnt_q;

endmodule

// File: doc/adc_lane_aligner.md
Name: adc_lane_aligner

Overview:
- Parametrised successor to the fixed 2-lane, 8-bit ADC capture path. Runs in the CLKDIV domain, downstream of the per-lane deserializers.
- Takes deserialized words from LANES data lanes plus one frame-clock lane. Trains word alignment automatically by pulsing a shared bitslip until the frame lane matches a known pattern.
- Monitors lock continuously and retrains on loss.
- Outputs the interleaved sample with a valid flag and lock/error status.

Parameters:
- LANES, 2, number of ADC data lanes (>=1).
- BITS, 8, deserialization ratio, i.e. bits per lane word (4..8).
- FRAME_PATTERN, 8'hF0, expected frame-lane word when aligned (BITS wide, LSBs used).
- SETTLE_CYCLES, 4, wait after each bitslip before sampling the frame word (>=1).
- MAX_SLIPS, 7, bitslip pulses allowed per training attempt before declaring failure.
- LOCK_COUNT, 16, consecutive frame matches required to declare lock (>=1).
- ERR_LIMIT, 4, consecutive frame mismatches while locked that cause lock loss (>=1).

Ports:
- CLK  in  1  CLKDIV-rate clock, same clock as the deserializer parallel outputs.
- RST_N  in  1  asynchronous active-low reset.
- start  in  1  level; request (re)training.
- lanes_in  in  LANES*BITS  deserialized lane words; lane l occupies bits [l*BITS +: BITS].
- frame_in  in  BITS  deserialized frame-lane word.
- bitslip  out  1  one-cycle pulse to all deserializers, including the frame lane.
- d_out  out  LANES*BITS  interleaved sample.
- d_valid  out  1  d_out holds an aligned sample.
- locked  out  1  alignment achieved and held.
- align_err  out  1  training exhausted MAX_SLIPS without a match.
- slip_count  out  $clog2(MAX_SLIPS+1)  bitslips issued in the current attempt.

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; all internal counters 0.
- Interleave rule: d_out[(BITS-1-j)*LANES + l] = lane l bit j. For LANES=2, BITS=8 the MSB is lane1 bit0 and the LSB is lane0 bit7.
- d_out is registered every cycle, giving 1-cycle latency from lanes_in.
- d_valid is registered alongside d_out. It is 1 only when the state is LOCKED and frame_in matched FRAME_PATTERN in the same input cycle.
- FSM:
  - IDLE: outputs quiet. start=1 -> SETTLE, with slip_count cleared and the settle counter loaded to SETTLE_CYCLES.
  - SETTLE: count down SETTLE_CYCLES cycles, then -> CHECK.
  - CHECK (one cycle):
    - frame_in==FRAME_PATTERN -> VERIFY, match counter=1.
    - Mismatch and slip_count==MAX_SLIPS -> FAIL.
    - Mismatch otherwise -> SLIP.
  - SLIP (one cycle): bitslip=1, slip_count+1, -> SETTLE.
  - VERIFY:
    - Each match increments the match counter; when it reaches LOCK_COUNT -> LOCKED.
    - With LOCK_COUNT=1, CHECK goes directly to LOCKED.
    - Any mismatch resets the match counter and goes to SLIP, or to FAIL if slip_count==MAX_SLIPS.
  - LOCKED:
    - locked=1. A mismatch increments the error counter; a match clears it.
    - When the error counter reaches ERR_LIMIT: locked=0, d_valid=0, slip_count cleared, -> SETTLE. This is a retrain without any start input.
  - FAIL: align_err=1, held until start=1. start=1 -> SETTLE, clearing align_err and slip_count.
- Timing of status outputs:
  - locked is asserted the cycle after the final VERIFY match.
  - bitslip is never asserted on two consecutive cycles; the minimum spacing is SETTLE_CYCLES+2.
- start while in SETTLE/CHECK/SLIP/VERIFY/LOCKED: restart training. Go to SETTLE, clear slip_count and the match/error counters, and drop locked/d_valid on the next cycle.
- start has priority over a simultaneous lock-loss or FAIL transition.
- slip_count saturates at MAX_SLIPS and never wraps.
- Reset asserted mid-operation: immediate return to the reset state. A bitslip pulse in progress is truncated.

Test Plan:
- Frame already aligned (frame_in=8'hF0 constant), start pulse -> zero bitslips; locked rises after SETTLE + CHECK + 15 VERIFY cycles. With lanes_in lane0=8'h01, lane1=8'h80: d_out=16'h4002, d_valid=1.
- Frame model rotated by 3 bits, with each bitslip rotating it by 1 -> exactly 5 bitslip pulses, each at least 6 cycles apart; slip_count=5; then locked=1, align_err=0.
- frame_in never matches (8'h00) -> 7 bitslips, then align_err=1, locked=0, d_valid=0. A later start with a correct frame -> align_err clears and locked=1.
- While locked, inject 3 mismatched frames then 1 match -> locked stays 1 and d_valid=0 only on the 3 bad cycles. Then inject 4 consecutive mismatches -> locked=0 and retraining begins with slip_count=0.
- Mismatch on the 10th VERIFY cycle -> match counter resets, one bitslip is issued, and verification restarts; lock requires 16 fresh consecutive matches.
- Assert RST_N low during SLIP -> bitslip drops immediately and all outputs are 0. Repeat with LANES=4, BITS=4: the interleave maps lane3 bit0 to d_out[15] and lane0 bit3 to d_out[0].
